// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port driver: command and response
// encodings, the driver FSM state type and the queued-operation bundle.
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;
    localparam logic [RESP_W-1:0] RESP_INT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA2,
        ST_WAIT,
        ST_HOLD
    } drv_state_t;

    // 68-bit queue entry: {cmd, data1, data2}
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [0:DATA_W-1] data1;
        logic [0:DATA_W-1] data2;
    } drv_op_t;

endpackage

// File: rtl/calc1_port_driver_if.sv
// Bundle of the driver's upstream op, calc1 request/response and
// downstream result signals.
//   master : environment side (drives ops, calc1 responses, res_ready)
//   slave  : calc1_port_driver side
interface calc1_port_driver_if;
    import calc1_pkg::*;

    logic                  op_valid;
    logic                  op_ready;
    logic [CMD_W-1:0]      op_cmd;
    logic [0:DATA_W-1]     op_data1;
    logic [0:DATA_W-1]     op_data2;

    logic [CMD_W-1:0]      req_cmd_out;
    logic [0:DATA_W-1]     req_data_out;
    logic [RESP_W-1:0]     out_resp;
    logic [0:DATA_W-1]     out_data;

    logic                  res_valid;
    logic                  res_ready;
    logic [RESP_W-1:0]     res_resp;
    logic [0:DATA_W-1]     res_data;

    logic                  busy;

    modport master (
        output op_valid, op_cmd, op_data1, op_data2,
        output out_resp, out_data, res_ready,
        input  op_ready, req_cmd_out, req_data_out,
        input  res_valid, res_resp, res_data, busy
    );

    modport slave (
        input  op_valid, op_cmd, op_data1, op_data2,
        input  out_resp, out_data, res_ready,
        output op_ready, req_cmd_out, req_data_out,
        output res_valid, res_resp, res_data, busy
    );

endinterface

// File: rtl/calc1_drv_fifo.sv
// Operation queue for the calc1 port driver (power-of-two depth).
// Ports: i_clk, i_rst (async, active high), i_push/i_data/o_full,
//        i_pop/o_data/o_empty (o_data is the head entry, show-ahead).
module calc1_drv_fifo
    import calc1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_push,
    input  drv_op_t i_data,
    output logic    o_full,
    input  logic    i_pop,
    output drv_op_t o_data,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    drv_op_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/calc1_port_driver.sv
// Sequences queued operations onto one calc1 request port (cmd+data1,
// then data2), waits for the response and holds it for downstream.
// Ports: c_clk, reset (async, active high), bus (calc1_port_driver_if.slave).
// Option: define CALC1_DRV_TIMEOUT_EN to give up after TIMEOUT_CYC WAIT
// cycles and report RESP_INT with zero data.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                c_clk,
    input  logic                reset,
    calc1_port_driver_if.slave  bus
);

    drv_state_t        r_state;
    drv_state_t        w_next;
    drv_op_t           r_op;
    logic [RESP_W-1:0] r_res_resp;
    logic [0:DATA_W-1] r_res_data;

    drv_op_t           w_fifo_in;
    drv_op_t           w_fifo_out;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_capture;
    logic [RESP_W-1:0] w_cap_resp;
    logic [0:DATA_W-1] w_cap_data;
    logic [CMD_W-1:0]  w_req_cmd;
    logic [0:DATA_W-1] w_req_data;
    logic              w_timeout;

    // Unsupported configurations leave this marker block in the hierarchy
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYC < 1) begin : g_bad_cfg
    end

    assign w_fifo_in = {bus.op_cmd, bus.op_data1, bus.op_data2};

    calc1_drv_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (c_clk),
        .i_rst   (reset),
        .i_push  (bus.op_valid),
        .i_data  (w_fifo_in),
        .o_full  (w_fifo_full),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_empty (w_fifo_empty)
    );

`ifdef CALC1_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_wait_cnt;

    // Counts completed WAIT cycles of the current command
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT && w_next == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) &&
                       (r_wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_capture  = 1'b0;
        w_cap_resp = bus.out_resp;
        w_cap_data = bus.out_data;
        w_req_cmd  = CMD_NOP;
        w_req_data = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_CMD;
                end
            end
            ST_CMD: begin
                w_req_cmd  = r_op.cmd;
                w_req_data = r_op.data1;
                w_next     = ST_DATA2;
            end
            ST_DATA2: begin
                w_req_data = r_op.data2;
                w_next     = ST_WAIT;
            end
            ST_WAIT: begin
                // A real response wins over a coincident timeout
                if (bus.out_resp != RESP_NONE) begin
                    w_capture = 1'b1;
                    w_next    = ST_HOLD;
                end else if (w_timeout) begin
                    w_capture  = 1'b1;
                    w_cap_resp = RESP_INT;
                    w_cap_data = '0;
                    w_next     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Go straight to the next command to keep 4-cycle spacing
                if (bus.res_ready) begin
                    if (!w_fifo_empty) begin
                        w_pop  = 1'b1;
                        w_next = ST_CMD;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_op       <= '0;
            r_res_resp <= RESP_NONE;
            r_res_data <= '0;
        end else begin
            if (w_pop) begin
                r_op <= w_fifo_out;
            end
            if (w_capture) begin
                r_res_resp <= w_cap_resp;
                r_res_data <= w_cap_data;
            end
        end
    end

    assign bus.op_ready     = !w_fifo_full;
    assign bus.req_cmd_out  = w_req_cmd;
    assign bus.req_data_out = w_req_data;
    assign bus.res_valid    = (r_state == ST_HOLD);
    assign bus.res_resp     = r_res_resp;
    assign bus.res_data     = r_res_data;
    assign bus.busy         = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: doc/calc1_port_driver.md
CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 Parameter FIFO_DEPTH, 4, operation-queue entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYC, 64, WAIT-state cycles before timeout (used only with CALC1_DRV_TIMEOUT_EN).
REQ-003 c_clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 op_valid  in  1  upstream operation valid.
REQ-006 op_ready  out  1  queue can accept (not full).
REQ-007 op_cmd  in  4  calc1 command (1 add, 2 sub, 5 shl, 6 shr; others passed through).
REQ-008 op_data1  in  [0:31]  first operand.
REQ-009 op_data2  in  [0:31]  second operand.
REQ-010 req_cmd_out  out  4  to calc1 reqN_cmd_in.
REQ-011 req_data_out  out  [0:31]  to calc1 reqN_data_in.
REQ-012 out_resp  in  2  from calc1 out_respN (0 none, 1 ok, 2 overflow/underflow/invalid, 3 internal error).
REQ-013 out_data  in  [0:31]  from calc1 out_dataN.
REQ-014 res_valid  out  1  result available downstream.
REQ-015 res_ready  in  1  downstream accepts result.
REQ-016 res_resp  out  2  captured response code.
REQ-017 res_data  out  [0:31]  captured result.
REQ-018 busy  out  1  high in any state except IDLE or when queue non-empty.

Function
REQ-019 Operation accepted into FIFO when op_valid && op_ready at rising edge; op_ready = !full.
REQ-020 FSM states: IDLE, CMD, DATA2, WAIT, HOLD.
REQ-021 IDLE -> CMD when FIFO non-empty; pop occurs on this transition.
REQ-022 CMD (1 cycle): req_cmd_out=op_cmd, req_data_out=op_data1; -> DATA2.
REQ-023 DATA2 (1 cycle): req_cmd_out=0, req_data_out=op_data2; -> WAIT.
REQ-024 WAIT: req_cmd_out=0, req_data_out=0; first cycle with out_resp!=0 captures out_resp/out_data into res_resp/res_data -> HOLD.
REQ-025 HOLD: res_valid=1, res_resp/res_data stable; res_ready -> IDLE (if FIFO non-empty, next CMD starts following cycle).
REQ-026 Exactly one outstanding calc1 command; minimum op-to-op spacing on req_cmd_out is 4 cycles.
REQ-027 Push on full FIFO ignored (op_ready low); simultaneous push and pop when full is not permitted; when empty, a pushed entry is poppable next cycle.
REQ-028 out_resp!=0 in IDLE, CMD, DATA2 or HOLD is discarded with no state change.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-030 Reset asserted: FSM=IDLE, FIFO emptied, op_ready=1 after release, req_cmd_out=0, req_data_out=0, res_valid=0, res_resp=0, res_data=0, busy=0.
REQ-031 Reset mid-operation abandons in-flight command; no result emitted for it.

Configuration
REQ-032 Macro CALC1_DRV_TIMEOUT_EN defined: WAIT counter; after TIMEOUT_CYC cycles with out_resp=0 go to HOLD with res_resp=3, res_data=0.
REQ-033 Macro undefined: no counter logic; WAIT persists until out_resp!=0.

Structure
REQ-034 Package calc1_pkg holds cmd encodings (CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR), response codes (RESP_NONE, RESP_OK, RESP_ERR, RESP_INT) and FSM state typedef.
REQ-035 FIFO is sub-module calc1_drv_fifo storing {cmd, data1, data2} (68 bits).

Verification
REQ-036 Push add 1h+1FF_FFFFh, calc1 returns resp 1 -> req_cmd_out 1 then 0, data 1h then 1FF_FFFFh; res_resp=1, res_data=200_0000h.
REQ-037 Push add FFFF_FFFFh+1h -> res_resp=2 delivered; subsequent op proceeds normally.
REQ-038 Push 5 ops with res_ready=0 -> op_ready low after queue full (4 queued + 1 in HOLD); releasing res_ready drains all 5 results in order.
REQ-039 Assert reset during WAIT -> all outputs 0 within same cycle, no res_valid after release, FIFO empty.
REQ-040 With CALC1_DRV_TIMEOUT_EN, out_resp held 0 -> res_resp=3, res_data=0 after 64 WAIT cycles.
REQ-041 Invalid cmd 3 pushed -> forwarded unchanged; calc1 resp 2 captured as res_resp=2.
